// File: rtl/zoe_seg_sequencer_if.sv
// ---------------------------------------------------------------------------
// zoe_seg_sequencer_if
//   Bundles the buffer-write, control and display signals of the
//   7-segment digit sequencer.
//   master : drives writes/control (wr_en, wr_addr, wr_data, len, start,
//            stop, hold, step), observes display outputs
//   slave  : the sequencer; drives code, code_valid, busy, wrap
// ---------------------------------------------------------------------------
interface zoe_seg_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] len;
    logic       start;
    logic       stop;
    logic       hold;
    logic       step;
    logic [3:0] code;
    logic       code_valid;
    logic       busy;
    logic       wrap;

    modport master (
        output wr_en, wr_addr, wr_data, len, start, stop, hold, step,
        input  code, code_valid, busy, wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, start, stop, hold, step,
        output code, code_valid, busy, wrap
    );
endinterface

// File: rtl/zoe_seg_sequencer.sv
// ---------------------------------------------------------------------------
// zoe_seg_sequencer
//   Steps through an 8-entry buffer of 4-bit digit codes, showing each for
//   MAX_COUNT clocks. Supports run, hold/single-step and stop.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears buffer too)
//   bus   : slave side of zoe_seg_sequencer_if
//           in : wr_en, wr_addr, wr_data, len, start, stop, hold, step
//           out: code, code_valid, busy, wrap (all registered)
// ---------------------------------------------------------------------------
module zoe_seg_sequencer #(
    parameter int unsigned MAX_COUNT = 1000,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    zoe_seg_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_e;

    state_e             state_q;
    logic [2:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         mem_q [DEPTH];
    logic               wrap_pend_q;
    logic [3:0]         code_q;
    logic               code_valid_q;
    logic               busy_q;
    logic               wrap_q;

    logic [2:0]         idx_adv_d;
    logic               wrap_adv_d;
    logic               tick_d;

    // Advance rule: any idx at or past len wraps to 0, so shrinking len
    // below the current idx forces a wrap on the next advance.
    always_comb begin
        wrap_adv_d = (idx_q >= bus.len);
        idx_adv_d  = wrap_adv_d ? 3'd0 : idx_q + 3'd1;
        tick_d     = (cnt_q == CNT_W'(MAX_COUNT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            wrap_pend_q  <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            wrap_q       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Outputs reflect the pre-edge state/idx/buffer (one cycle behind).
            code_q       <= (state_q != IDLE) ? mem_q[idx_q] : '0;
            code_valid_q <= (state_q != IDLE);
            busy_q       <= (state_q != IDLE);
            // Wrap is delayed one extra stage so it lines up with the
            // code returning to entry 0.
            wrap_q       <= wrap_pend_q;
            wrap_pend_q  <= 1'b0;

            if (bus.wr_en) begin
                mem_q[bus.wr_addr] <= bus.wr_data;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (bus.start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else if (bus.hold && bus.step) begin
                        state_q <= PAUSE;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (bus.start) begin
                        idx_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        // A tick coinciding with hold still advances.
                        if (tick_d) begin
                            cnt_q       <= '0;
                            idx_q       <= idx_adv_d;
                            wrap_pend_q <= wrap_adv_d;
                        end else if (!bus.hold) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (bus.hold) begin
                            state_q <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                    end else if (bus.start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end else if (!bus.hold) begin
                        state_q <= RUN;
                    end else if (bus.step) begin
                        idx_q       <= idx_adv_d;
                        wrap_pend_q <= wrap_adv_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.busy       = busy_q;
    assign bus.wrap       = wrap_q;
endmodule
